// File: rtl/clk_div_multi_if.sv
// -----------------------------------------------------------------------------
// clk_div_multi_if
// Load bus for the multi-channel clock divider. A requester (master) offers a
// new divisor/duty pair for one channel; the divider (slave) signals whether
// that channel can take it this cycle.
//
// Signals:
//   ld_valid  master->slave  load request
//   ld_ch     master->slave  target channel (CW bits)
//   ld_div    master->slave  requested divisor (W bits)
//   ld_duty   master->slave  requested duty threshold (W bits)
//   ld_ready  slave->master  selected channel has no load pending
// -----------------------------------------------------------------------------
interface clk_div_multi_if #(
  parameter int W   = 26,
  parameter int NCH = 2
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          ld_valid;
  logic [CW-1:0] ld_ch;
  logic [W-1:0]  ld_div;
  logic [W-1:0]  ld_duty;
  logic          ld_ready;

  modport master (
    output ld_valid,
    output ld_ch,
    output ld_div,
    output ld_duty,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_ch,
    input  ld_div,
    input  ld_duty,
    output ld_ready
  );
endinterface

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// Multi-channel programmable tick/clock divider. Each channel counts
// 0..div-1 while en is high, emits a one-cycle tick on the last count and a
// level output q that is high while the count is at or above the duty
// threshold. New divisor/duty values are parked in a shadow register and
// applied only at the channel's next wrap, so the output never glitches.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   sync      (only with CLKDIV_SYNC_EN) restart all channels at count 0
//   en        global count enable
//   ld        load bus (clk_div_multi_if.slave): ld_valid/ld_ch/ld_div/
//             ld_duty in, ld_ready out
//   q         divided level output per channel
//   tick      one-cycle wrap strobe per channel
//   pend      per-channel load-pending flag
//
// Optional feature macro: CLKDIV_SYNC_EN adds the sync input.
// -----------------------------------------------------------------------------
module clk_div_multi #(
  parameter int W        = 26,
  parameter int NCH      = 2,
  parameter int DEF_DIV  = 25000000,
  parameter int DEF_DUTY = DEF_DIV / 2
) (
  input  logic           clk,
  input  logic           reset,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync,
`endif
  input  logic           en,
  clk_div_multi_if.slave ld,
  output logic [NCH-1:0] q,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pend
);

  localparam int           CW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [W-1:0] ONE_W      = W'(1'b1);
  localparam logic [W-1:0] TWO_W      = W'(2'd2);
  localparam logic [W-1:0] DEF_DIV_W  = W'(DEF_DIV);
  localparam logic [W-1:0] DEF_DUTY_W = W'(DEF_DUTY);

  logic [W-1:0]   cnt_r   [NCH];
  logic [W-1:0]   div_r   [NCH];
  logic [W-1:0]   duty_r  [NCH];
  logic [W-1:0]   sdiv_r  [NCH];
  logic [W-1:0]   sduty_r [NCH];
  logic [NCH-1:0] pend_r;

  logic [NCH-1:0] wrap_s;
  logic [NCH-1:0] tick_s;
  logic [NCH-1:0] q_s;
  logic           ready_s;
  logic           accept_s;
  logic [W-1:0]   div_clamp_s;
  logic           sync_s;

`ifdef CLKDIV_SYNC_EN
  assign sync_s = sync;
`else
  assign sync_s = 1'b0;
`endif

  // Decode wrap, tick and level outputs from the registered channel state.
  always_comb begin
    wrap_s = '0;
    tick_s = '0;
    q_s    = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap_s[i] = (cnt_r[i] == (div_r[i] - ONE_W));
      // A sync restart cuts the running period short, so it never ticks.
      tick_s[i] = en & wrap_s[i] & ~sync_s;
      q_s[i]    = (cnt_r[i] >= duty_r[i]);
    end
  end

  // Load handshake: ready only for an existing channel with no pending load.
  // Channel numbers at or beyond NCH match no loop index and stay not-ready.
  always_comb begin
    ready_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      ready_s = (ld.ld_ch == CW'(i)) ? ~pend_r[i] : ready_s;
    end
    accept_s    = ld.ld_valid & ready_s;
    // Divisors below 2 cannot produce a distinct tick, so they become 2.
    div_clamp_s = (ld.ld_div < TWO_W) ? TWO_W : ld.ld_div;
  end

  assign ld.ld_ready = ready_s;
  assign q           = q_s;
  assign tick        = tick_s;
  assign pend        = pend_r;

  // Per-channel counter, shadow registers and wrap-time apply of pending loads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        cnt_r[i]   <= '0;
        div_r[i]   <= DEF_DIV_W;
        duty_r[i]  <= DEF_DUTY_W;
        sdiv_r[i]  <= DEF_DIV_W;
        sduty_r[i] <= DEF_DUTY_W;
        pend_r[i]  <= 1'b0;
      end else begin
        if (sync_s || (en && wrap_s[i])) begin
          cnt_r[i] <= '0;
          if (pend_r[i]) begin
            div_r[i]  <= sdiv_r[i];
            duty_r[i] <= sduty_r[i];
            pend_r[i] <= 1'b0;
          end
        end else if (en) begin
          cnt_r[i] <= cnt_r[i] + ONE_W;
        end
        // Accept only happens with pend clear, so it never races the apply.
        if (accept_s && (ld.ld_ch == CW'(i))) begin
          sdiv_r[i]  <= div_clamp_s;
          sduty_r[i] <= ld.ld_duty;
          pend_r[i]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
// Self-checking bench for clk_div_multi (W=8, NCH=2, DEF_DIV=10, DEF_DUTY=5).
// A driver applies one input vector per cycle, predicts the outputs with a
// behavioural model (phase position within each channel's period) and queues
// the prediction; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;
  localparam int W        = 8;
  localparam int NCH      = 2;
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DEF_DIV  = 10;
  localparam int DEF_DUTY = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           sync;
  logic           en;
  logic [NCH-1:0] q;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pend;

  clk_div_multi_if #(.W(W), .NCH(NCH)) ld_bus ();

  clk_div_multi #(
    .W(W), .NCH(NCH), .DEF_DIV(DEF_DIV), .DEF_DUTY(DEF_DUTY)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef CLKDIV_SYNC_EN
    .sync  (sync),
`endif
    .en    (en),
    .ld    (ld_bus),
    .q     (q),
    .tick  (tick),
    .pend  (pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] q;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;
    logic           rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   started = 1'b0;

  // Reference model: position inside the current period, period length,
  // duty threshold and an optional pending (period, duty) pair per channel.
  int m_pos[NCH];
  int m_per[NCH];
  int m_duty[NCH];
  int m_sper[NCH];
  int m_sduty[NCH];
  bit m_pv[NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i]  = 0;
      m_per[i]  = DEF_DIV;
      m_duty[i] = DEF_DUTY;
      m_pv[i]   = 1'b0;
    end
  endtask

  task automatic check(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // One clock cycle: drive inputs, queue the predicted outputs, advance model.
  task automatic step(input bit e, input bit r, input bit s, input bit lv,
                      input int ch, input int dv, input int dt);
    exp_t x;
    bit   acc;
    en              = e;
    reset           = r;
    sync            = s;
    ld_bus.ld_valid = lv;
    ld_bus.ld_ch    = CW'(ch);
    ld_bus.ld_div   = W'(dv);
    ld_bus.ld_duty  = W'(dt);
    for (int i = 0; i < NCH; i++) begin
      x.q[i]    = (m_pos[i] >= m_duty[i]);
      x.tick[i] = e && !s && (m_pos[i] == m_per[i] - 1);
      x.pend[i] = m_pv[i];
    end
    x.rdy = (ch < NCH) ? !m_pv[ch] : 1'b0;
    exp_q.push_back(x);
    acc = lv && x.rdy;
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (s || (e && m_pos[i] == m_per[i] - 1)) begin
          m_pos[i] = 0;
          if (m_pv[i]) begin
            m_per[i]  = m_sper[i];
            m_duty[i] = m_sduty[i];
            m_pv[i]   = 1'b0;
          end
        end else if (e) begin
          m_pos[i] = m_pos[i] + 1;
        end
        if (acc && ch == i) begin
          m_sper[i]  = (dv < 2) ? 2 : dv;
          m_sduty[i] = dt;
          m_pv[i]    = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // Monitor: compare every presented output against the queued prediction.
  always @(negedge clk) begin
    exp_t x;
    if (started) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        x = exp_q.pop_front();
        check("q", int'(q), int'(x.q));
        check("tick", int'(tick), int'(x.tick));
        check("pend", int'(pend), int'(x.pend));
        check("ld_ready", int'(ld_bus.ld_ready), int'(x.rdy));
      end
    end
  end

  initial begin
    reset           = 1'b1;
    sync            = 1'b0;
    en              = 1'b0;
    ld_bus.ld_valid = 1'b0;
    ld_bus.ld_ch    = '0;
    ld_bus.ld_div   = '0;
    ld_bus.ld_duty  = '0;
    @(posedge clk);
    #1;
    model_reset();
    started = 1'b1;

    // Reset state, then default 10-cycle period with 5/5 duty.
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(40);
    // Load ch1 mid-period, then a second load to it while pending.
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1, 4, 1);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1, 6, 3);
    idle(25);
    // Divisor clamp and duty extremes.
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 1);
    idle(30);
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 10, 200);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1, 3, 2);
    idle(30);
    // Hold with en=0, then resume.
    idle(6);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(5);
    // Reset while a load is pending.
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 5, 2);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1, 7, 3);
    idle(25);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      bit e, r, s, lv;
      int ch, dv, dt;
      e  = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 299) == 0);
`ifdef CLKDIV_SYNC_EN
      s  = ($urandom_range(0, 99) == 0);
`else
      s  = 1'b0;
`endif
      lv = ($urandom_range(0, 2) == 0);
      ch = $urandom_range(0, NCH - 1);
      dv = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      dt = $urandom_range(0, 14);
      step(e, r, s, lv, ch, dv, dt);
    end

    started = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
